// File: rtl/aes_pkg.sv
// Shared definitions for the AES stream controller.
//   - Controller state encoding (DRAIN/IDLE/LOAD/ARM/WAIT/OUT)
//   - AES key-size codes understood by the iterative core
//   - Block and core-key width constants
package aes_pkg;

  localparam int BLK_W      = 128;
  localparam int CORE_KEY_W = 256;

  localparam logic [1:0] AES_128 = 2'b00;
  localparam logic [1:0] AES_192 = 2'b01;
  localparam logic [1:0] AES_256 = 2'b10;

  typedef enum logic [2:0] {
    DRAIN = 3'd0,
    IDLE  = 3'd1,
    LOAD  = 3'd2,
    ARM   = 3'd3,
    WAIT  = 3'd4,
    OUT   = 3'd5
  } state_t;

endpackage

// File: rtl/aes_wdog.sv
// Watchdog counter for the AES core.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - restart the count at zero
//   en          - count this cycle (controller is waiting on the core)
//   timeout     - high during the MAX_WAIT-th enabled cycle after clr
module aes_wdog #(
  parameter int MAX_WAIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  // Saturates at MAX_WAIT so a stalled controller never wraps back into range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(MAX_WAIT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The first enabled cycle sees cnt==0, so the MAX_WAIT-th sees MAX_WAIT-1.
  assign timeout = en && (cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/aes_stream_ctrl.sv
// Valid/ready stream front end for an iterative AES-128 core.
// Accepts one 128-bit block at a time, launches it into the core with a
// one-cycle load pulse, waits for busy to fall, and presents the result on
// an output stream. Counts completed output handshakes and flags core
// protocol errors / watchdog timeouts on a sticky error bit.
//
// Optional build macro AES_CBC_EN: adds iv_i / iv_load_i and CBC chaining.
// Without it the controller runs plain ECB.
//
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   cfg_key_i, cfg_dec_i        - key and direction, sampled on input handshake
//   in_valid_i/in_data_i/in_ready_o    - input block stream
//   out_valid_o/out_data_o/out_ready_i - result block stream
//   core_load_o, core_key_o, core_data_o, core_size_o, core_dec_o - to core
//   core_data_i, core_busy_i    - from core
//   blk_cnt_o                   - completed output handshakes (wrapping)
//   err_o                       - sticky timeout / protocol error
//   iv_i, iv_load_i             - (AES_CBC_EN only) chaining IV load in IDLE
module aes_stream_ctrl
  import aes_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64,
  parameter int KEY_W    = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEY_W-1:0]      cfg_key_i,
  input  logic                  cfg_dec_i,
  input  logic                  in_valid_i,
  input  logic [BLK_W-1:0]      in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [BLK_W-1:0]      out_data_o,
  input  logic                  out_ready_i,
  output logic                  core_load_o,
  output logic [CORE_KEY_W-1:0] core_key_o,
  output logic [BLK_W-1:0]      core_data_o,
  output logic [1:0]            core_size_o,
  output logic                  core_dec_o,
  input  logic [BLK_W-1:0]      core_data_i,
  input  logic                  core_busy_i,
  output logic [CNT_W-1:0]      blk_cnt_o,
`ifdef AES_CBC_EN
  input  logic [BLK_W-1:0]      iv_i,
  input  logic                  iv_load_i,
`endif
  output logic                  err_o
);

  state_t state, nxt;

  logic [KEY_W-1:0] key_r;
  logic [BLK_W-1:0] blk_r;
  logic [BLK_W-1:0] out_data_r;
  logic             dec_r;
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;

  logic accept;
  logic capture;
  logic proto_err;
  logic wd_clr;
  logic wd_en;
  logic wd_timeout;
  logic expire;

`ifdef AES_CBC_EN
  logic [BLK_W-1:0] in_r;
  logic [BLK_W-1:0] chain_r;
`endif

  aes_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .timeout (wd_timeout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DRAIN;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      // The core is never reset with us; wait for it to go quiet first.
      DRAIN: if (!core_busy_i) nxt = IDLE;
      IDLE:  if (accept)       nxt = LOAD;
      LOAD:                    nxt = ARM;
      // Busy must be up one cycle after load, otherwise the core ignored us.
      ARM:   nxt = core_busy_i ? WAIT : IDLE;
      WAIT: begin
        if (!core_busy_i) nxt = OUT;
        else if (expire)  nxt = DRAIN;
      end
      OUT:   if (out_ready_i)  nxt = IDLE;
      default:                 nxt = DRAIN;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready_o  = 1'b0;
    core_load_o = 1'b0;
    out_valid_o = 1'b0;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    case (state)
`ifdef AES_CBC_EN
      // An IV load wins over a block in the same cycle.
      IDLE: in_ready_o = !iv_load_i;
`else
      IDLE: in_ready_o = 1'b1;
`endif
      LOAD: core_load_o = 1'b1;
      ARM:  wd_clr      = 1'b1;
      WAIT: wd_en       = 1'b1;
      OUT:  out_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign accept    = in_valid_i && in_ready_o;
  assign capture   = (state == WAIT) && !core_busy_i;
  assign proto_err = (state == ARM) && !core_busy_i;
  assign expire    = (state == WAIT) && core_busy_i && wd_timeout;

  // Block / key / direction registers, and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r      <= '0;
      dec_r      <= 1'b0;
      blk_r      <= '0;
      out_data_r <= '0;
    end else begin
      if (accept) begin
        key_r <= cfg_key_i;
        dec_r <= cfg_dec_i;
`ifdef AES_CBC_EN
        // Pre-whitening is folded in here so core_data_o stays constant
        // while chain_r moves at capture time.
        blk_r <= cfg_dec_i ? in_data_i : (in_data_i ^ chain_r);
`else
        blk_r <= in_data_i;
`endif
      end
      if (capture) begin
`ifdef AES_CBC_EN
        out_data_r <= dec_r ? (core_data_i ^ chain_r) : core_data_i;
`else
        out_data_r <= core_data_i;
`endif
      end
    end
  end

`ifdef AES_CBC_EN
  // Chaining state: ciphertext of the previous block in either direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_r    <= '0;
      chain_r <= '0;
    end else begin
      if (accept) in_r <= in_data_i;
      if ((state == IDLE) && iv_load_i) begin
        chain_r <= iv_i;
      end else if (capture) begin
        chain_r <= dec_r ? in_r : core_data_i;
      end
    end
  end
`endif

  // Completed-block counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      if ((state == OUT) && out_ready_i) cnt_r <= cnt_r + CNT_W'(1);
      if (proto_err || expire)           err_r <= 1'b1;
    end
  end

  assign out_data_o  = out_data_r;
  assign core_data_o = blk_r;
  assign core_dec_o  = dec_r;
  assign core_key_o  = {key_r, {(CORE_KEY_W - KEY_W){1'b0}}};
  assign core_size_o = AES_128;
  assign blk_cnt_o   = cnt_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with a behavioural AES core stub.
// The stub answers from a small table of known AES-128 vectors and models
// 11 (encrypt) / 22 (decrypt) busy cycles; it can be told to hang busy.
module tb_aes_stream_ctrl;

  localparam int CNT_W    = 3;
  localparam int MAX_WAIT = 64;
  localparam int KEY_W    = 128;

  logic         clk;
  logic         rst_n;
  logic [127:0] cfg_key_i;
  logic         cfg_dec_i;
  logic         in_valid_i;
  logic [127:0] in_data_i;
  logic         in_ready_o;
  logic         out_valid_o;
  logic [127:0] out_data_o;
  logic         out_ready_i;
  logic         core_load_o;
  logic [255:0] core_key_o;
  logic [127:0] core_data_o;
  logic [1:0]   core_size_o;
  logic         core_dec_o;
  logic [127:0] core_data_i;
  logic         core_busy_i;
  logic [CNT_W-1:0] blk_cnt_o;
  logic         err_o;
`ifdef AES_CBC_EN
  logic [127:0] iv_i;
  logic         iv_load_i;
`endif

  aes_stream_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT), .KEY_W(KEY_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_key_i   (cfg_key_i),
    .cfg_dec_i   (cfg_dec_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .core_load_o (core_load_o),
    .core_key_o  (core_key_o),
    .core_data_o (core_data_o),
    .core_size_o (core_size_o),
    .core_dec_o  (core_dec_o),
    .core_data_i (core_data_i),
    .core_busy_i (core_busy_i),
    .blk_cnt_o   (blk_cnt_o),
`ifdef AES_CBC_EN
    .iv_i        (iv_i),
    .iv_load_i   (iv_load_i),
`endif
    .err_o       (err_o)
  );

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;

  // Core stub vector table: AES_k(a) == b
  logic [127:0] tk [3];
  logic [127:0] ta [3];
  logic [127:0] tb [3];

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- core stub ----------------
  logic         stub_busy = 1'b0;
  logic         hang      = 1'b0;
  int           stub_left = 0;
  logic [127:0] stub_res  = '0;
  logic [127:0] stub_data = '0;

  function automatic logic [127:0] stub_lookup(input logic [127:0] k,
                                               input logic [127:0] d,
                                               input logic dec);
    logic [127:0] r;
    r = 128'hbadbadbadbadbadbadbadbadbadbad00;
    for (int i = 0; i < 3; i++) begin
      if (tk[i] == k) begin
        if (!dec && ta[i] == d) r = tb[i];
        if (dec && tb[i] == d)  r = ta[i];
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (core_load_o && !stub_busy) begin
      stub_busy <= 1'b1;
      stub_left <= core_dec_o ? 22 : 11;
      stub_res  <= stub_lookup(core_key_o[255:128], core_data_o, core_dec_o);
    end else if (stub_busy && !hang) begin
      if (stub_left == 1) begin
        stub_busy <= 1'b0;
        stub_data <= stub_res;
      end
      stub_left <= stub_left - 1;
    end
  end

  assign core_busy_i = stub_busy;
  assign core_data_i = stub_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a block at the current sample point; it is accepted on the next edge.
  task automatic send(input logic [127:0] k, input logic [127:0] d,
                      input logic dec, input string nm);
    cfg_key_i  = k;
    in_data_i  = d;
    cfg_dec_i  = dec;
    in_valid_i = 1'b1;
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_in_ready: got %b want 1", nm, in_ready_o);
    end
    step();
    in_valid_i = 1'b0;
  endtask

  // Called at the sample point just after the handshake edge.
  task automatic wait_out(input logic [127:0] exp, input int exp_lat,
                          input string nm, input bit complete);
    int k;
    int loads;
    bit seen;
    k = 0;
    loads = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      if (core_load_o === 1'b1) loads++;
      if (out_valid_o === 1'b1) seen = 1'b1;
      else begin
        step();
        k++;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s_valid: out_valid never rose within %0d cycles", nm, k);
      return;
    end
    if (exp_lat >= 0) begin
      n_cmp++;
      if (k != exp_lat) begin
        n_bad++;
        $display("FAIL %s_latency: got A+%0d want A+%0d", nm, k, exp_lat);
      end
    end
    n_cmp++;
    if (loads != 1) begin
      n_bad++;
      $display("FAIL %s_load_pulses: got %0d want 1", nm, loads);
    end
    n_cmp++;
    if (out_data_o !== exp) begin
      n_bad++;
      $display("FAIL %s_data: got %h want %h", nm, out_data_o, exp);
    end
    if (complete) begin
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      n_cmp++;
      if (out_valid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_valid_drop: got %b want 0", nm, out_valid_o);
      end
    end
  endtask

  task automatic check_cnt(input logic [CNT_W-1:0] exp, input string nm);
    n_cmp++;
    if (blk_cnt_o !== exp) begin
      n_bad++;
      $display("FAIL %s_blk_cnt: got %0d want %0d", nm, blk_cnt_o, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({in_ready_o, out_valid_o, core_load_o, err_o, core_dec_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {in_ready_o, out_valid_o, core_load_o, err_o, core_dec_o});
    end
    n_cmp++;
    if ({out_data_o, core_data_o, core_key_o, core_size_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: out=%h core_data=%h key=%h size=%b want all 0",
               out_data_o, core_data_o, core_key_o, core_size_o);
    end
    check_cnt(0, "reset");
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_to_idle: in_ready got %b want 1", in_ready_o);
    end
  endtask

  task automatic test_encrypt();
    send(K0, P0, 1'b0, "enc");
    n_cmp++;
    if (core_key_o !== {K0, 128'h0} || core_data_o !== P0 || core_dec_o !== 1'b0) begin
      n_bad++;
      $display("FAIL enc_core_in: key=%h data=%h dec=%b want %h %h 0",
               core_key_o, core_data_o, core_dec_o, {K0, 128'h0}, P0);
    end
    wait_out(C0, 13, "enc", 1'b1);
    check_cnt(1, "enc");
  endtask

  task automatic test_decrypt();
    send(K0, C0, 1'b1, "dec");
    wait_out(P0, 24, "dec", 1'b1);
    check_cnt(2, "dec");
  endtask

  task automatic test_backpressure();
    send(K0, P0, 1'b0, "bp1");
    wait_out(C0, 13, "bp1", 1'b0);
    in_valid_i = 1'b1;
    in_data_i  = C0;
    cfg_dec_i  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if ({out_valid_o, in_ready_o, core_load_o, out_data_o} !== {3'b100, C0}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: valid/ready/load=%b%b%b data=%h want 100 %h",
                 i, out_valid_o, in_ready_o, core_load_o, out_data_o, C0);
      end
    end
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    n_cmp++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_release: valid/ready=%b%b want 01", out_valid_o, in_ready_o);
    end
    step();
    in_valid_i = 1'b0;
    n_cmp++;
    if (core_load_o !== 1'b1 || core_data_o !== C0 || core_dec_o !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_next_accept: load=%b data=%h dec=%b want 1 %h 1",
               core_load_o, core_data_o, core_dec_o, C0);
    end
    wait_out(P0, 24, "bp2", 1'b1);
    check_cnt(4, "bp");
  endtask

  task automatic test_timeout();
    int k;
    bit saw_valid;
    k = 0;
    saw_valid = 1'b0;
    hang = 1'b1;
    send(K0, P0, 1'b0, "to");
    while (err_o !== 1'b1 && k < 300) begin
      if (out_valid_o === 1'b1) saw_valid = 1'b1;
      step();
      k++;
    end
    n_cmp++;
    if (k != 2 + MAX_WAIT) begin
      n_bad++;
      $display("FAIL to_err_time: err after A+%0d want A+%0d", k, 2 + MAX_WAIT);
    end
    n_cmp++;
    if (saw_valid) begin
      n_bad++;
      $display("FAIL to_no_output: out_valid got 1 want 0");
    end
    repeat (5) step();
    n_cmp++;
    if ({in_ready_o, out_valid_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL to_drain: ready/valid=%b%b want 00", in_ready_o, out_valid_o);
    end
    hang = 1'b0;
    k = 0;
    while (in_ready_o !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    n_cmp++;
    if (in_ready_o !== 1'b1 || core_busy_i !== 1'b0) begin
      n_bad++;
      $display("FAIL to_recover: in_ready=%b busy=%b want 1 0", in_ready_o, core_busy_i);
    end
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL to_err_sticky: got %b want 1", err_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    int k;
    send(K0, P0, 1'b0, "rmw");
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready_o, out_valid_o, core_load_o, err_o, blk_cnt_o, out_data_o,
         core_data_o, core_dec_o, core_key_o} !== '0) begin
      n_bad++;
      $display("FAIL rmw_async_clear: ready=%b valid=%b load=%b err=%b cnt=%0d out=%h",
               in_ready_o, out_valid_o, core_load_o, err_o, blk_cnt_o, out_data_o);
    end
    step();
    rst_n = 1'b1;
    k = 0;
    while (core_busy_i === 1'b1 && k < 40) begin
      n_cmp++;
      if (in_ready_o !== 1'b0) begin
        n_bad++;
        $display("FAIL rmw_drain_ready: got %b want 0 while busy", in_ready_o);
      end
      step();
      k++;
    end
    k = 0;
    while (in_ready_o !== 1'b1 && k < 3) begin
      step();
      k++;
    end
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rmw_idle: in_ready got %b want 1", in_ready_o);
    end
    send(K0, P0, 1'b0, "rmw2");
    wait_out(C0, 13, "rmw2", 1'b1);
    check_cnt(1, "rmw");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) begin
      send(K0, P0, 1'b0, "wrap");
      wait_out(C0, 13, "wrap", 1'b1);
    end
    check_cnt(0, "wrap");
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_err: got %b want 0", err_o);
    end
  endtask

`ifdef AES_CBC_EN
  task automatic load_iv();
    iv_i       = IV;
    iv_load_i  = 1'b1;
    in_valid_i = 1'b1;
    n_cmp++;
    if (in_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL cbc_iv_priority: in_ready got %b want 0", in_ready_o);
    end
    step();
    iv_load_i  = 1'b0;
    in_valid_i = 1'b0;
    n_cmp++;
    if (core_load_o !== 1'b0) begin
      n_bad++;
      $display("FAIL cbc_iv_no_accept: core_load got %b want 0", core_load_o);
    end
  endtask

  task automatic test_cbc();
    load_iv();
    send(K1, P1, 1'b0, "cbc_e1");
    wait_out(C1, 13, "cbc_e1", 1'b1);
    send(K1, P2, 1'b0, "cbc_e2");
    wait_out(C2, 13, "cbc_e2", 1'b1);
    load_iv();
    send(K1, C1, 1'b1, "cbc_d1");
    wait_out(P1, 24, "cbc_d1", 1'b1);
    send(K1, C2, 1'b1, "cbc_d2");
    wait_out(P2, 24, "cbc_d2", 1'b1);
  endtask
`endif

  initial begin
    tk[0] = K0; ta[0] = P0;      tb[0] = C0;
    tk[1] = K1; ta[1] = P1 ^ IV; tb[1] = C1;
    tk[2] = K1; ta[2] = P2 ^ C1; tb[2] = C2;
    rst_n       = 1'b0;
    cfg_key_i   = '0;
    cfg_dec_i   = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
`ifdef AES_CBC_EN
    iv_i        = '0;
    iv_load_i   = 1'b0;
`endif
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_wrap();
`ifdef AES_CBC_EN
    test_cbc();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
- Initiator for the iterative AES core. It drives the core's load/key/data/dec inputs and monitors its busy/data outputs.
- Converts the core's load-pulse/busy protocol into valid/ready streams, one 128-bit block at a time.
- Sits between the bus-side block FIFO and the AES core. It holds the per-block key and direction, counts completed blocks, and runs a watchdog on the core.

Parameters:
- CNT_W, 16, width of the completed-block counter.
- MAX_WAIT, 64, number of cycles allowed in WAIT before a timeout is declared.
- KEY_W, 128, cipher key width. Only AES-128 is supported; core_size_o is tied to 2'b00.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_key_i  in  KEY_W  key; sampled on input handshake.
- cfg_dec_i  in  1  1 = decrypt; sampled on input handshake.
- in_valid_i  in  1  input block valid.
- in_data_i  in  128  input block.
- in_ready_o  out  1  controller can accept a block.
- out_valid_o  out  1  result valid.
- out_data_o  out  128  result block.
- out_ready_i  in  1  downstream accepts result.
- core_load_o  out  1  one-cycle load pulse to core.
- core_key_o  out  256  {key_r, 128'h0}.
- core_data_o  out  128  block to core.
- core_size_o  out  2  constant 2'b00.
- core_dec_o  out  1  latched direction.
- core_data_i  in  128  core result.
- core_busy_i  in  1  core busy.
- blk_cnt_o  out  CNT_W  completed output handshakes; wraps modulo 2^CNT_W.
- err_o  out  1  sticky timeout/protocol error; cleared only by reset.

Behaviour:
- Reset (async, rst_n low):
  - State goes to DRAIN.
  - All outputs go to 0, including out_data_o, blk_cnt_o, err_o and core_load_o.
  - Internal key/data/dec registers are cleared.
- Reset mid-operation: the core is not reset and may still be busy. DRAIN holds in_ready_o=0 until core_busy_i==0 is sampled, then goes to IDLE. Any core result produced during DRAIN is discarded.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o: latch in_data_i, cfg_key_i and cfg_dec_i, then go to LOAD.
- LOAD:
  - core_load_o=1 for exactly one cycle.
  - core_data_o, core_key_o and core_dec_o are stable from this cycle until the next LOAD.
  - Next state: ARM.
- ARM:
  - Waits one cycle while the core registers busy.
  - If core_busy_i==0 in ARM: set err_o and go to IDLE (protocol error).
  - Otherwise go to WAIT.
- WAIT:
  - The watchdog counter resets on entry and increments every cycle.
  - When core_busy_i==0: register core_data_i into out_data_o, set out_valid_o, go to OUT.
  - When the counter reaches MAX_WAIT with busy still high: set err_o, go to DRAIN, emit no output.
- OUT:
  - out_valid_o and out_data_o are held until out_ready_i.
  - On the handshake: out_valid_o drops the next cycle, blk_cnt_o increments (wraps to 0 from all-ones), go to IDLE.
  - in_ready_o=0 throughout OUT; only one block is in flight.
- Latency, measured from the input-handshake edge A:
  - The core samples load at A+1.
  - Encrypt: 11 busy cycles; out_valid_o is high from edge A+13.
  - Decrypt: 22 busy cycles; out_valid_o is high from edge A+24.
- Throughput: at most one block per (latency + 2) cycles.
- Simultaneous events: in_valid_i during OUT is ignored (not accepted). out_ready_i held high in OUT completes the handshake on the first OUT cycle.

Optional Feature:
- Macro: AES_CBC_EN.
- When defined, add ports iv_i (in, 128) and iv_load_i (in, 1). iv_load_i in IDLE loads chain_r<=iv_i; it takes priority over an input handshake in the same cycle.
- Encrypt:
  - core_data_o = in_r ^ chain_r.
  - On capture, chain_r <= core_data_i.
- Decrypt:
  - core_data_o = in_r.
  - out_data_o = core_data_i ^ chain_r.
  - On capture, chain_r <= in_r.
- chain_r resets to 0.
- When undefined: ECB mode, no iv ports, no chain register.

Decomposition:
- Shared package aes_pkg holds:
  - State encoding DRAIN/IDLE/LOAD/ARM/WAIT/OUT.
  - AES_128/192/256 size constants.
  - The 128/256 width constants.
- One sub-module, aes_wdog: a loadable counter with a MAX_WAIT compare, giving the timeout pulse.

Test Plan:
- Encrypt, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff: out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid_o at A+13, blk_cnt_o=1.
- Decrypt of the same ciphertext, same key: out 00112233445566778899aabbccddeeff at A+24; core_load_o high exactly one cycle.
- Backpressure: out_ready_i held low 20 cycles. out_data_o stable, in_ready_o=0, a second in_valid_i is not accepted; on release the next block is accepted in the following IDLE.
- Core stub holds busy forever: err_o=1 after MAX_WAIT WAIT cycles, no out_valid_o. After the stub drops busy, in_ready_o returns to 1.
- rst_n pulsed low mid-WAIT: all outputs 0 immediately, in_ready_o stays 0 until core_busy_i low, then a new block completes correctly.
- AES_CBC_EN: NIST SP800-38A F.2.1 (IV 000102..0f, key 2b7e1516...). Block 1 = 7649abac8119b246cee98e9b12e9197d; block 2 = 5086cb9b507219ee95db113a917678b2; decrypt round-trips.
